reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side counterpart to the register bank read path. It collects results from the ALU and the load unit and drives the register bank's single write port.
- It performs load sign/zero extension and byte/halfword lane selection, arbitrates the two result sources, and buffers a stalled ALU result.
- It maintains a retired-write counter.
- Sits between execute/memory stages and the reg_bank write port.

Parameters:
data_width, 32, register/result width
addr_width, 5, register index width (32 registers)
cnt_width, 32, retire counter width

Ports:
clk  input  1  system clock
rst  input  1  reset
alu_valid  input  1  ALU result valid
alu_ready  output  1  writeback can accept ALU result
alu_rd  input  addr_width  ALU destination register
alu_result  input  data_width  ALU result
mem_valid  input  1  load data valid; always accepted, no ready
mem_rd  input  addr_width  load destination register
mem_funct3  input  3  load type (RV32I encoding)
mem_addr_lo  input  2  low bits of load byte address
mem_rdata  input  data_width  raw aligned memory word
rf_we  output  1  register bank write enable
rf_waddr  output  addr_width  register bank write address
rf_wdata  output  data_width  register bank write data
retire_count  output  cnt_width  number of writebacks performed (including rd=0)
wb_err  output  1  one-cycle pulse: illegal load funct3

Behaviour:
- Clock and reset: single clock clk, rising edge. rst is synchronous and active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, retire_count=0, wb_err=0. The skid buffer is emptied, so alu_ready=1 in the first cycle after reset.
- Reset mid-operation: any buffered ALU result is discarded and never written.
- Skid buffer: one entry holding buf_valid, buf_rd and buf_data. alu_ready = !buf_valid (combinational from the register). An ALU transfer occurs when alu_valid && alu_ready.
- Per-cycle selection, in priority order:
  1. mem_valid: the load is written. If an ALU transfer also occurs this cycle, the ALU result goes into the buffer.
  2. buf_valid: the buffered entry is written and the buffer clears. alu_ready is 0 this cycle, so no new ALU transfer.
  3. ALU transfer: the ALU result is written directly.
  4. None of the above: rf_we=0 next cycle.
- While mem_valid stays high with buf_valid=1, the buffer holds and alu_ready stays 0.
- Latency: the selected write appears on rf_we/rf_waddr/rf_wdata exactly one cycle after selection. All outputs are registered.
- x0 handling: if the selected rd == 0, rf_we=0 and rf_waddr/rf_wdata hold their previous values. retire_count still increments.
- Load extension, by mem_funct3:
  - 000 LB: byte mem_rdata[8*addr_lo +: 8], sign-extended.
  - 001 LH: halfword mem_rdata[16*addr_lo[1] +: 16], sign-extended. addr_lo[0] is ignored.
  - 010 LW: full word; addr_lo is ignored.
  - 100 LBU / 101 LHU: same lane selection as LB/LH, zero-extended.
  - 011, 110, 111 (illegal): no write (rf_we=0), no retire increment, wb_err=1 for one cycle. The load still consumes its selection slot, so a buffered ALU result does not drain that cycle.
- retire_count: increments by 1 in the cycle rf_we would be asserted for any legal selection (rd=0 included). Wraps modulo 2^cnt_width.
- wb_err: deasserts the cycle after the pulse unless another illegal load arrives.

Test Plan:
- Reset then ALU write: alu_valid=1, alu_rd=5, alu_result=32'hDEADBEEF for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF, retire_count=1, alu_ready=1 throughout.
- Collision: same cycle mem_valid (rd=3, LW, rdata=32'h11223344) and ALU (rd=7, data=32'hA5) -> cycle+1: write r3=11223344. alu_ready=0 for one cycle. cycle+2: write r7=000000A5. retire_count=2.
- Load extension with rdata=32'h80FF7F01:
  - LB addr_lo=3 -> FFFFFF80.
  - LBU addr_lo=3 -> 00000080.
  - LH addr_lo=2 -> FFFF80FF.
  - LHU addr_lo=0 -> 00007F01.
  - LB addr_lo=1 -> 0000007F.
- x0 and illegal: ALU rd=0, data=1234 -> rf_we=0, retire_count+1. Load funct3=3'b011 -> rf_we=0, wb_err pulses one cycle, retire_count unchanged.
- Sustained loads: mem_valid held high 3 cycles while ALU rd=9 is buffered -> alu_ready=0 for all 3 cycles. r9 is written in the cycle after mem_valid drops (output one cycle later).
- Reset mid-operation: buffer full (rd=4), rst=1 for one cycle -> after reset rf_we never asserts for r4, retire_count=0, alu_ready=1.

Source files
------------

// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - ALU/load result inputs and register-bank write port of the writeback stage
interface reg_writeback_if #(
    parameter int data_width = 32,
    parameter int addr_width = 5,
    parameter int cnt_width  = 32
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [addr_width-1:0] alu_rd;
    logic [data_width-1:0] alu_result;
    logic                  mem_valid;
    logic [addr_width-1:0] mem_rd;
    logic [2:0]            mem_funct3;
    logic [1:0]            mem_addr_lo;
    logic [data_width-1:0] mem_rdata;
    logic                  rf_we;
    logic [addr_width-1:0] rf_waddr;
    logic [data_width-1:0] rf_wdata;
    logic [cnt_width-1:0]  retire_count;
    logic                  wb_err;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output mem_valid, mem_rd, mem_funct3, mem_addr_lo, mem_rdata,
        input  alu_ready, rf_we, rf_waddr, rf_wdata, retire_count, wb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  mem_valid, mem_rd, mem_funct3, mem_addr_lo, mem_rdata,
        output alu_ready, rf_we, rf_waddr, rf_wdata, retire_count, wb_err
    );
endinterface

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - load extension, ALU/load arbitration with one-entry ALU skid buffer, reg-bank write port
module reg_writeback #(
    parameter int data_width = 32,
    parameter int addr_width = 5,
    parameter int cnt_width  = 32
) (
    input  logic             clk,
    input  logic             rst,
    reg_writeback_if.slave   wb
);
    logic                  buf_valid_q, buf_valid_d;
    logic [addr_width-1:0] buf_rd_q, buf_rd_d;
    logic [data_width-1:0] buf_data_q, buf_data_d;
    logic                  rf_we_q, rf_we_d;
    logic [addr_width-1:0] rf_waddr_q, rf_waddr_d;
    logic [data_width-1:0] rf_wdata_q, rf_wdata_d;
    logic [cnt_width-1:0]  retire_count_q, retire_count_d;
    logic                  wb_err_q, wb_err_d;

    logic                  alu_xfer;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [data_width-1:0] load_data;
    logic                  load_legal;
    logic                  sel_valid;
    logic [addr_width-1:0] sel_rd;
    logic [data_width-1:0] sel_data;

    assign wb.alu_ready = !buf_valid_q;
    assign alu_xfer     = wb.alu_valid && !buf_valid_q;

    always_comb begin
        byte_lane  = wb.mem_rdata[8*wb.mem_addr_lo +: 8];
        half_lane  = wb.mem_rdata[16*wb.mem_addr_lo[1] +: 16];
        load_data  = '0;
        load_legal = 1'b1;
        case (wb.mem_funct3)
            3'b000:  load_data = {{(data_width-8){byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{(data_width-16){half_lane[15]}}, half_lane};
            3'b010:  load_data = wb.mem_rdata;
            3'b100:  load_data = {{(data_width-8){1'b0}}, byte_lane};
            3'b101:  load_data = {{(data_width-16){1'b0}}, half_lane};
            default: load_legal = 1'b0;
        endcase
    end

    // Loads have no back-pressure, so they always win; a colliding ALU result parks in the buffer.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        sel_valid   = 1'b0;
        sel_rd      = '0;
        sel_data    = '0;
        wb_err_d    = 1'b0;
        if (wb.mem_valid) begin
            sel_valid = load_legal;
            sel_rd    = wb.mem_rd;
            sel_data  = load_data;
            wb_err_d  = !load_legal;
            if (alu_xfer) begin
                buf_valid_d = 1'b1;
                buf_rd_d    = wb.alu_rd;
                buf_data_d  = wb.alu_result;
            end
        end else if (buf_valid_q) begin
            sel_valid   = 1'b1;
            sel_rd      = buf_rd_q;
            sel_data    = buf_data_q;
            buf_valid_d = 1'b0;
        end else if (alu_xfer) begin
            sel_valid = 1'b1;
            sel_rd    = wb.alu_rd;
            sel_data  = wb.alu_result;
        end
    end

    // Writes to x0 retire but leave the write port address/data untouched.
    always_comb begin
        rf_we_d        = sel_valid && (sel_rd != '0);
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        retire_count_d = retire_count_q;
        if (rf_we_d) begin
            rf_waddr_d = sel_rd;
            rf_wdata_d = sel_data;
        end
        if (sel_valid) begin
            retire_count_d = retire_count_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q    <= 1'b0;
            buf_rd_q       <= '0;
            buf_data_q     <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            retire_count_q <= '0;
            wb_err_q       <= 1'b0;
        end else begin
            buf_valid_q    <= buf_valid_d;
            buf_rd_q       <= buf_rd_d;
            buf_data_q     <= buf_data_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_count_q <= retire_count_d;
            wb_err_q       <= wb_err_d;
        end
    end

    assign wb.rf_we        = rf_we_q;
    assign wb.rf_waddr     = rf_waddr_q;
    assign wb.rf_wdata     = rf_wdata_q;
    assign wb.retire_count = retire_count_q;
    assign wb.wb_err       = wb_err_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed bench for reg_writeback with a queue-based reference model
module tb_reg_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_writeback_if #(.data_width(32), .addr_width(5), .cnt_width(32)) wb ();
    reg_writeback #(.data_width(32), .addr_width(5), .cnt_width(32)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results waiting behind a load sit in a queue of at most one entry.
    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    ent_t        pend[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_cnt;
    logic        m_err;

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [1:0] lo,
                                             input logic [31:0] w, output bit ok);
        logic [31:0] b, h;
        ok = 1'b1;
        b  = (w >> (8 * lo)) & 32'hFF;
        h  = (w >> (16 * (lo / 2))) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: begin ok = 1'b0; return 32'd0; end
        endcase
    endfunction

    task automatic m_write(input logic [4:0] rd, input logic [31:0] d);
        m_cnt = m_cnt + 1;
        m_we  = (rd != 0);
        if (rd != 0) begin
            m_waddr = rd;
            m_wdata = d;
        end
    endtask

    always @(posedge clk) begin
        bit          acc;
        bit          ok;
        logic [31:0] v;
        ent_t        e;
        if (rst) begin
            m_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_err = 0;
            pend.delete();
        end else begin
            acc   = wb.alu_valid && (pend.size() == 0);
            m_err = 0;
            if (wb.mem_valid) begin
                v = load_val(wb.mem_funct3, wb.mem_addr_lo, wb.mem_rdata, ok);
                if (ok) m_write(wb.mem_rd, v);
                else begin m_we = 0; m_err = 1; end
                if (acc) pend.push_back('{wb.alu_rd, wb.alu_result});
            end else if (pend.size() != 0) begin
                e = pend.pop_front();
                m_write(e.rd, e.d);
            end else if (acc) begin
                m_write(wb.alu_rd, wb.alu_result);
            end else begin
                m_we = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("rf_we", {31'd0, wb.rf_we}, {31'd0, m_we});
            chk("rf_waddr", {27'd0, wb.rf_waddr}, {27'd0, m_waddr});
            chk("rf_wdata", wb.rf_wdata, m_wdata);
            chk("retire_count", wb.retire_count, m_cnt);
            chk("wb_err", {31'd0, wb.wb_err}, {31'd0, m_err});
            chk("alu_ready", {31'd0, wb.alu_ready}, {31'd0, pend.size() == 0});
        end
    end

    task automatic idle_in();
        wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_result = 0;
        wb.mem_valid = 0; wb.mem_rd = 0; wb.mem_funct3 = 0; wb.mem_addr_lo = 0; wb.mem_rdata = 0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
        wb.alu_valid = 1; wb.alu_rd = rd; wb.alu_result = d;
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic [2:0] f, input logic [1:0] lo, input logic [31:0] w);
        wb.mem_valid = 1; wb.mem_rd = rd; wb.mem_funct3 = f; wb.mem_addr_lo = lo; wb.mem_rdata = w;
    endtask

    // Advance one cycle; on return the outputs reflect the inputs just presented.
    task automatic cyc();
        @(posedge clk); #1;
        @(negedge clk);
        idle_in();
    endtask

    logic [2:0]  lf  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [1:0]  llo [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] lexp[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F};

    initial begin
        idle_in();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("reset rf_we", {31'd0, wb.rf_we}, 32'd0);
        chk("reset retire_count", wb.retire_count, 32'd0);
        chk("reset alu_ready", {31'd0, wb.alu_ready}, 32'd1);

        set_alu(5'd5, 32'hDEADBEEF);
        cyc();
        chk("alu rf_we", {31'd0, wb.rf_we}, 32'd1);
        chk("alu rf_waddr", {27'd0, wb.rf_waddr}, 32'd5);
        chk("alu rf_wdata", wb.rf_wdata, 32'hDEADBEEF);
        chk("alu retire", wb.retire_count, 32'd1);
        chk("alu ready", {31'd0, wb.alu_ready}, 32'd1);

        set_mem(5'd3, 3'b010, 2'd0, 32'h11223344);
        set_alu(5'd7, 32'hA5);
        cyc();
        chk("coll load waddr", {27'd0, wb.rf_waddr}, 32'd3);
        chk("coll load wdata", wb.rf_wdata, 32'h11223344);
        chk("coll alu_ready low", {31'd0, wb.alu_ready}, 32'd0);
        cyc();
        chk("coll drain waddr", {27'd0, wb.rf_waddr}, 32'd7);
        chk("coll drain wdata", wb.rf_wdata, 32'h000000A5);
        chk("coll retire", wb.retire_count, 32'd3);

        for (int i = 0; i < 5; i++) begin
            set_mem(5'(10 + i), lf[i], llo[i], 32'h80FF7F01);
            cyc();
            chk($sformatf("load ext %0d", i), wb.rf_wdata, lexp[i]);
        end

        set_alu(5'd0, 32'd1234);
        cyc();
        chk("x0 rf_we", {31'd0, wb.rf_we}, 32'd0);
        chk("x0 wdata held", wb.rf_wdata, 32'h0000007F);
        chk("x0 retire", wb.retire_count, 32'd9);
        set_mem(5'd6, 3'b011, 2'd0, 32'hFFFFFFFF);
        cyc();
        chk("illegal rf_we", {31'd0, wb.rf_we}, 32'd0);
        chk("illegal wb_err", {31'd0, wb.wb_err}, 32'd1);
        chk("illegal retire", wb.retire_count, 32'd9);
        cyc();
        chk("wb_err clears", {31'd0, wb.wb_err}, 32'd0);

        set_mem(5'd20, 3'b010, 2'd0, 32'h00000020);
        set_alu(5'd9, 32'h99);
        cyc();
        chk("sustain ready 1", {31'd0, wb.alu_ready}, 32'd0);
        set_mem(5'd21, 3'b010, 2'd0, 32'h00000021);
        cyc();
        chk("sustain ready 2", {31'd0, wb.alu_ready}, 32'd0);
        set_mem(5'd22, 3'b110, 2'd0, 32'h00000022);
        cyc();
        chk("sustain ready 3", {31'd0, wb.alu_ready}, 32'd0);
        chk("sustain illegal err", {31'd0, wb.wb_err}, 32'd1);
        chk("sustain r21 held", wb.rf_wdata, 32'h00000021);
        cyc();
        chk("sustain r9 waddr", {27'd0, wb.rf_waddr}, 32'd9);
        chk("sustain r9 wdata", wb.rf_wdata, 32'h00000099);
        chk("sustain ready back", {31'd0, wb.alu_ready}, 32'd1);

        set_mem(5'd2, 3'b010, 2'd0, 32'h22);
        set_alu(5'd4, 32'h44);
        cyc();
        chk("pre-reset buffered", {31'd0, wb.alu_ready}, 32'd0);
        rst = 1;
        cyc();
        rst = 0;
        chk("mid reset retire", wb.retire_count, 32'd0);
        chk("mid reset ready", {31'd0, wb.alu_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("no r4 write", {31'd0, wb.rf_we}, 32'd0);
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
